audio_sample_packer: RTL and testbench
======================================

Name: audio_sample_packer

Overview:
- Upstream feeder for the 4-lane PWM audio stage.
- Accepts a byte-wide sample stream over a valid/ready handshake and packs four consecutive samples into one 32-bit word.
- Buffers packed words in a small FIFO.
- Presents the head word on fifo_rd_data, qualified by aud_en, and pops it on the PWM frame boundary.
- Tracks the PWM frame with its own free-running frame counter, so the consumer needs no pop strobe.

Parameters:
- DATA_WIDTH, 8: sample width and PWM resolution. The frame is 4*2^DATA_WIDTH cycles.
- FIFO_DATA_WIDTH, 32: packed word width. Must equal 4*DATA_WIDTH.
- DEPTH, 16: FIFO depth in words. Must be a power of 2, at least 2.
- START_LEVEL, 4: number of words required before playback starts (prime threshold). Range 1..DEPTH.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- s_data  in  DATA_WIDTH  input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept s_data this cycle
- flush  in  1  synchronous flush of FIFO, packer and playback state
- fifo_rd_data  out  FIFO_DATA_WIDTH  head word; lane 0 in bits [7:0] = oldest sample
- aud_en  out  1  fifo_rd_data is valid for the consumer this frame
- level  out  $clog2(DEPTH)+1  words currently stored
- underrun  out  1  sticky: FIFO was empty at a frame boundary during PLAY

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rstn. All state is cleared on rstn=0.
- Reset values:
  - s_ready=1, fifo_rd_data=0, aud_en=0, level=0, underrun=0
  - frm_cnt=0, pack_cnt=0, state=PRIME
- Frame counter:
  - frm_cnt is DATA_WIDTH+2 bits. It increments every cycle and wraps from all-ones to 0.
  - frame_tick = (frm_cnt == all-ones). This is the cycle on which the consumer samples fifo_rd_data.
  - flush does not touch frm_cnt; it must stay in phase with the consumer counter.
- Packer:
  - A transfer occurs when s_valid && s_ready. The byte goes to lane pack_cnt, then pack_cnt increments.
  - On the transfer with pack_cnt==3, the assembled word is written to the FIFO and pack_cnt returns to 0.
  - s_ready = !(level==DEPTH && pack_cnt==3). Lanes 0..2 can still be filled while the FIFO is full.
  - s_ready is computed from registered state only. A same-cycle pop does not raise s_ready.
- FIFO:
  - Register array with wr_ptr and rd_ptr. fifo_rd_data = mem[rd_ptr] when level != 0, otherwise 0.
  - Pop occurs at the clock edge ending a frame_tick cycle when aud_en=1.
  - Push and pop in the same cycle: level is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- State machine:
  - PRIME:
    - aud_en=0.
    - Go to PLAY when level >= START_LEVEL. Evaluated every cycle; takes effect the next cycle.
  - PLAY:
    - aud_en = (level != 0).
    - At a frame_tick with level==0: set underrun, go to PRIME.
    - A word pushed on the frame_tick cycle itself does not avoid the underrun.
- flush=1:
  - Next cycle: level=0, pointers=0, pack_cnt=0, state=PRIME, underrun=0. Partially packed bytes are discarded.
  - s_valid is ignored while flush=1.
  - flush has priority over push, pop and frame_tick.
- Latency:
  - The 4th byte accepted at cycle N is visible in level at N+1.
  - In PRIME with START_LEVEL=1, aud_en=1 at N+2.

Optional Feature:
- Macro: AUDIO_SILENCE_FILL_EN.
- Defined:
  - While aud_en would be 0 (PRIME, or PLAY with level==0), drive fifo_rd_data = {4{1'b1, (DATA_WIDTH-1)'b0}} (0x80808080) and aud_en=1.
  - The consumer then holds mid-scale silence instead of the last duty. No pop occurs on fill frames.
- Undefined: behaviour exactly as above; aud_en=0 and fifo_rd_data=0 while not playing.

Test Plan:
- Reset, then push bytes 0x11,0x22,0x33,0x44 with START_LEVEL=1 -> level=1 and fifo_rd_data=0x44332211. aud_en rises 2 cycles after the 4th byte. Pop at the next frame_tick; level returns to 0.
- Push 16 words plus 3 bytes (DEPTH=16) with no frame ticks elapsed -> s_ready=1 through the 67th byte, s_ready=0 with 67 bytes accepted. The next pop raises s_ready one cycle later.
- Prime with 4 words, stop input -> aud_en high for exactly 4 frames. At the 5th frame_tick underrun=1 and state returns to PRIME with aud_en=0.
- Push 2 bytes, assert flush for 1 cycle, then push 0xA0..0xA3 -> only 0xA3A2A1A0 is stored. underrun cleared; frm_cnt phase unchanged across the flush.
- Push a word so it is written on the exact frame_tick cycle a pop occurs with level=1 -> level stays 1, the popped and new words are correct, no underrun.
- With AUDIO_SILENCE_FILL_EN defined, empty FIFO after reset -> aud_en=1 and fifo_rd_data=0x80808080. Real words replace the fill once level reaches START_LEVEL.

Source files
------------

// File: rtl/audio_sample_packer.sv
// ============================================================================
// Module   : audio_sample_packer
// Purpose  : Packs a byte-wide sample stream (valid/ready) into 32-bit words
//            of four samples, buffers them in a small FIFO and presents the
//            head word to a 4-lane PWM stage. A free-running frame counter
//            that stays in phase with the consumer pops one word per PWM
//            frame, so the consumer needs no pop strobe.
// Build    : Define AUDIO_SILENCE_FILL_EN to drive mid-scale silence words
//            (aud_en=1) whenever no real word is playing.
// Ports    : clk          - system clock
//            rstn         - asynchronous active-low reset
//            s_data       - input sample
//            s_valid      - s_data valid
//            s_ready      - block can accept s_data this cycle
//            flush        - synchronous flush of FIFO, packer, playback state
//            fifo_rd_data - head word, lane 0 in [DATA_WIDTH-1:0] = oldest
//            aud_en       - fifo_rd_data valid for the consumer this frame
//            level        - words currently stored
//            underrun     - sticky: FIFO empty at a frame boundary in PLAY
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_sample_packer #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DATA_WIDTH = 32,   // must equal 4*DATA_WIDTH
  parameter int DEPTH           = 16,   // power of 2, >= 2
  parameter int START_LEVEL     = 4     // 1..DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       flush,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                       aud_en,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = DATA_WIDTH + 2;

  localparam logic [AW:0]   c_DEPTH     = DEPTH[AW:0];
  localparam logic [AW:0]   c_START     = START_LEVEL[AW:0];
  localparam logic [AW:0]   c_LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] c_PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] c_FRM_ONE   = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [1:0]    c_LAST_LANE = 2'd3;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_PLAY  = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [FW-1:0]                r_frm_cnt;
  logic [1:0]                   r_pack_cnt;
  logic [3*DATA_WIDTH-1:0]      r_lanes;
  logic [FIFO_DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_rd_ptr;
  logic [AW:0]                  r_level;
  logic                         r_underrun;

  logic                         w_frame_tick;
  logic                         w_xfer;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_playing;
  logic                         w_set_underrun;
  logic [FIFO_DATA_WIDTH-1:0]   w_word;
  logic [FIFO_DATA_WIDTH-1:0]   w_head;

  // Frame counter: free-running and deliberately untouched by flush so it
  // never drifts from the consumer's own PWM counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_frm_cnt <= '0;
    else       r_frm_cnt <= r_frm_cnt + c_FRM_ONE;
  end

  assign w_frame_tick = &r_frm_cnt;

  // Only the final lane can overflow a full FIFO, so lanes 0..2 keep
  // accepting. Registered state only: a same-cycle pop does not help.
  assign s_ready = !((r_level == c_DEPTH) && (r_pack_cnt == c_LAST_LANE));
  assign w_xfer  = s_valid && s_ready && !flush;
  assign w_push  = w_xfer && (r_pack_cnt == c_LAST_LANE);
  assign w_word  = {s_data, r_lanes};
  assign w_pop   = w_frame_tick && w_playing && !flush;

  // Packer: lanes 0..2 are held here, the 4th byte goes straight into the word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pack_cnt <= '0;
      r_lanes    <= '0;
    end else if (flush) begin
      r_pack_cnt <= '0;
      r_lanes    <= '0;
    end else if (w_xfer) begin
      r_pack_cnt <= r_pack_cnt + 2'd1;
      case (r_pack_cnt)
        2'd0:    r_lanes[DATA_WIDTH-1:0]              <= s_data;
        2'd1:    r_lanes[2*DATA_WIDTH-1:DATA_WIDTH]   <= s_data;
        2'd2:    r_lanes[3*DATA_WIDTH-1:2*DATA_WIDTH] <= s_data;
        default: r_lanes                              <= r_lanes;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head = (r_level != '0) ? r_mem[r_rd_ptr] : '0;

  // Playback state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_state <= ST_PRIME;
    else if (flush) r_state <= ST_PRIME;
    else            r_state <= w_state_next;
  end

  // Next-state and playback qualifiers. Underrun uses the registered level,
  // so a word landing on the tick cycle itself does not rescue the frame.
  always_comb begin
    w_state_next   = r_state;
    w_playing      = 1'b0;
    w_set_underrun = 1'b0;
    case (r_state)
      ST_PRIME: begin
        if (r_level >= c_START) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        w_playing = (r_level != '0);
        if (w_frame_tick && (r_level == '0)) begin
          w_set_underrun = 1'b1;
          w_state_next   = ST_PRIME;
        end
      end
      default: w_state_next = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               r_underrun <= 1'b0;
    else if (flush)          r_underrun <= 1'b0;
    else if (w_set_underrun) r_underrun <= 1'b1;
  end

  assign level    = r_level;
  assign underrun = r_underrun;

`ifdef AUDIO_SILENCE_FILL_EN
  // Mid-scale word keeps every PWM lane at 50% duty instead of a stale duty.
  localparam logic [FIFO_DATA_WIDTH-1:0] c_SILENCE =
    {4{1'b1, {(DATA_WIDTH-1){1'b0}}}};

  assign aud_en       = 1'b1;
  assign fifo_rd_data = w_playing ? w_head : c_SILENCE;
`else
  assign aud_en       = w_playing;
  assign fifo_rd_data = w_head;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_packer.sv
// ============================================================================
// Module   : tb_audio_sample_packer
// Purpose  : Directed self-checking bench for audio_sample_packer
//            (DATA_WIDTH=8, DEPTH=16, START_LEVEL=1, frame = 1024 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_sample_packer;

`ifdef AUDIO_SILENCE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  localparam logic [31:0] SIL = 32'h8080_8080;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        flush = 1'b0;
  logic [31:0] fifo_rd_data;
  logic        aud_en;
  logic [4:0]  level;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  // Bench copy of the consumer's frame counter (reset together with the DUT).
  logic [9:0] tb_frm;

  audio_sample_packer #(
    .DATA_WIDTH(8), .FIFO_DATA_WIDTH(32), .DEPTH(16), .START_LEVEL(1)
  ) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .fifo_rd_data(fifo_rd_data),
    .aud_en(aud_en), .level(level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_frm <= '0;
    else       tb_frm <= tb_frm + 10'd1;
  end

  function automatic logic [31:0] mkword(input logic [7:0] b0);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_data = b; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_frm(input logic [9:0] target);
    int n = 0;
    while (tb_frm !== target && n < 2000) begin
      tick();
      n++;
    end
    if (tb_frm !== target) begin
      checks++; errors++;
      $display("FAIL wait_frm timeout: frm=%0d want %0d", tb_frm, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (aud_en !== FILL) begin errors++; $display("FAIL reset_aud_en: got %b want %b", aud_en, FILL); end
    checks++; if (fifo_rd_data !== (FILL ? SIL : 32'h0)) begin errors++; $display("FAIL reset_data: got %h want %h", fifo_rd_data, FILL ? SIL : 32'h0); end
  endtask

  task automatic test_basic();
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    // cycle N+1
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", level); end
    checks++; if (aud_en !== FILL) begin errors++; $display("FAIL basic_aud_en_n1: got %b want %b", aud_en, FILL); end
    checks++; if (fifo_rd_data !== (FILL ? SIL : 32'h44332211)) begin errors++; $display("FAIL basic_data_n1: got %h want %h", fifo_rd_data, FILL ? SIL : 32'h44332211); end
    tick(); // cycle N+2
    checks++; if (aud_en !== 1'b1) begin errors++; $display("FAIL basic_aud_en_n2: got %b want 1", aud_en); end
    checks++; if (fifo_rd_data !== 32'h44332211) begin errors++; $display("FAIL basic_data_n2: got %h want 44332211", fifo_rd_data); end
    wait_frm(10'd1023);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_level_tick: got %0d want 1", level); end
    tick();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_level_popped: got %0d want 0", level); end
    checks++; if (aud_en !== FILL) begin errors++; $display("FAIL basic_aud_en_empty: got %b want %b", aud_en, FILL); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_back_to_back_full();
    int not_ready = 0;
    do_reset();
    for (int i = 0; i < 67; i++) begin
      if (s_ready !== 1'b1) not_ready++;
      push_byte(8'(i));
    end
    checks++; if (not_ready != 0) begin errors++; $display("FAIL full_ready_during_fill: got %0d stalls want 0", not_ready); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
    // Offered byte while not ready must not be taken.
    s_data = 8'hEE; s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    wait_frm(10'd1023);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready_on_pop_cycle: got %b want 0", s_ready); end
    checks++; if (fifo_rd_data !== mkword(8'h00)) begin errors++; $display("FAIL full_head0: got %h want %h", fifo_rd_data, mkword(8'h00)); end
    tick();
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_level_after_pop: got %0d want 15", level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", s_ready); end
    checks++; if (fifo_rd_data !== mkword(8'h04)) begin errors++; $display("FAIL full_head1: got %h want %h", fifo_rd_data, mkword(8'h04)); end
    push_byte(8'h43);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_refill_level: got %0d want 16", level); end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    for (int f = 0; f < 4; f++) begin
      wait_frm(10'd1023);
      checks++; if (aud_en !== 1'b1 || level !== 5'(4 - f)) begin errors++; $display("FAIL underrun_frame%0d: got en=%b lvl=%0d want en=1 lvl=%0d", f, aud_en, level, 4 - f); end
      checks++; if (fifo_rd_data !== mkword(8'(8'h20 + 4 * f))) begin errors++; $display("FAIL underrun_word%0d: got %h want %h", f, fifo_rd_data, mkword(8'(8'h20 + 4 * f))); end
      tick();
    end
    wait_frm(10'd1023);
    checks++; if (level !== 5'd0 || underrun !== 1'b0 || aud_en !== FILL) begin errors++; $display("FAIL underrun_5th_tick: got lvl=%0d ur=%b en=%b want 0 0 %b", level, underrun, aud_en, FILL); end
    tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", underrun); end
    checks++; if (aud_en !== FILL || fifo_rd_data !== (FILL ? SIL : 32'h0)) begin errors++; $display("FAIL underrun_prime_out: got en=%b d=%h want en=%b", aud_en, fifo_rd_data, FILL); end
  endtask

  // Continues from test_underrun: underrun=1, PRIME, frame phase 0.
  task automatic test_flush();
    push_byte(8'h55); push_byte(8'h66);
    flush = 1'b1; s_data = 8'hFF; s_valid = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (underrun !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL flush_clear: got ur=%b lvl=%0d want 0 0", underrun, level); end
    push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_level: got %0d want 1", level); end
    tick();
    checks++; if (fifo_rd_data !== 32'hA3A2A1A0 || aud_en !== 1'b1) begin errors++; $display("FAIL flush_word: got %h en=%b want a3a2a1a0 en=1", fifo_rd_data, aud_en); end
    wait_frm(10'd1023);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_phase_pre: got %0d want 1", level); end
    tick();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_phase_pop: got %0d want 0", level); end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h30 + i));
    wait_frm(10'd1020);
    push_byte(8'hD0); push_byte(8'hD1); push_byte(8'hD2);
    s_data = 8'hD3; s_valid = 1'b1; // frame_tick cycle
    checks++; if (level !== 5'd1 || aud_en !== 1'b1 || fifo_rd_data !== mkword(8'h30)) begin errors++; $display("FAIL pp_before: got lvl=%0d en=%b d=%h want 1 1 %h", level, aud_en, fifo_rd_data, mkword(8'h30)); end
    tick();
    s_valid = 1'b0;
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL pp_level: got %0d want 1", level); end
    checks++; if (fifo_rd_data !== 32'hD3D2D1D0) begin errors++; $display("FAIL pp_word: got %h want d3d2d1d0", fifo_rd_data); end
    checks++; if (underrun !== 1'b0 || aud_en !== 1'b1) begin errors++; $display("FAIL pp_status: got ur=%b en=%b want 0 1", underrun, aud_en); end
  endtask

  task automatic test_silence_fill();
    do_reset();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    checks++; if (aud_en !== FILL || fifo_rd_data !== (FILL ? SIL : 32'h0)) begin errors++; $display("FAIL fill_partial: got en=%b d=%h want en=%b", aud_en, fifo_rd_data, FILL); end
    push_byte(8'h04);
    tick();
    checks++; if (aud_en !== 1'b1 || fifo_rd_data !== 32'h04030201) begin errors++; $display("FAIL fill_real: got en=%b d=%h want 1 04030201", aud_en, fifo_rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_full();
    test_underrun();
    test_flush();
    test_push_pop_same();
    test_silence_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
